csr_unit: RTL and testbench

Parametrised machine-mode CSR file, successor to the minimal four-register CSR block. It adds CSRRW/CSRRS/CSRRC semantics, an mstatus MIE/MPIE trap/return stack, timer-interrupt gating, vectored mtvec, mscratch, 64-bit mcycle/minstret counters and illegal-access detection. It sits beside the execute stage, which supplies decoded CSR operations, trap/mret strobes and retire pulses, and consumes read data, the trap target and mepc.

---
 rtl/csr_unit.sv | 179 +++++++++++++++++
 tb/tb_csr_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file: CSRRW/RS/RC access, MIE/MPIE trap stack, timer interrupt
// gating, vectored mtvec and 64-bit mcycle/minstret counters. DATA_LEN must be 32 or 64.
module csr_unit #(
    parameter int                  DATA_LEN  = 32,
    parameter logic [DATA_LEN-1:0] MTVEC_RST = '0,
    parameter logic [DATA_LEN-1:0] HART_ID   = '0,
    parameter logic [31:0]         MISA_VAL  = 32'h4000_0100
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ren,
    input  logic                wen,
    input  logic [1:0]          op,
    input  logic [11:0]         addr,
    input  logic [DATA_LEN-1:0] wdata,
    input  logic [DATA_LEN-1:0] pc,
    input  logic                trap,
    input  logic [DATA_LEN-1:0] cause,
    input  logic                mret,
    input  logic                instret_inc,
    input  logic                timer_irq,
    output logic [DATA_LEN-1:0] rdata,
    output logic                illegal,
    output logic                irq_req,
    output logic [DATA_LEN-1:0] trap_target,
    output logic [DATA_LEN-1:0] mepc
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [DATA_LEN-1:0] ALIGN_MASK = {{(DATA_LEN-2){1'b1}}, 2'b00};

    logic                mie_bit;
    logic                mpie_bit;
    logic                mtie;
    logic [DATA_LEN-1:0] mtvec;
    logic [DATA_LEN-1:0] mscratch;
    logic [DATA_LEN-1:0] mepc_q;
    logic [DATA_LEN-1:0] mcause;
    logic [63:0]         mcycle;
    logic [63:0]         minstret;

    logic                impl;
    logic [DATA_LEN-1:0] csr_cur;
    logic [DATA_LEN-1:0] csr_new;
    logic [63:0]         new_ext;
    logic                csr_we;
    logic [63:0]         cycle_nxt;
    logic [63:0]         instret_nxt;
    logic [DATA_LEN-1:0] tvec_base;
    logic [DATA_LEN-1:0] tvec_off;

    always_comb begin
        impl    = 1'b1;
        csr_cur = '0;
        case (addr)
            ADDR_MSTATUS: begin
                csr_cur[12:11] = 2'b11;
                csr_cur[7]     = mpie_bit;
                csr_cur[3]     = mie_bit;
            end
            ADDR_MISA:     csr_cur = DATA_LEN'(MISA_VAL);
            ADDR_MIE:      csr_cur[7] = mtie;
            ADDR_MTVEC:    csr_cur = mtvec;
            ADDR_MSCRATCH: csr_cur = mscratch;
            ADDR_MEPC:     csr_cur = mepc_q;
            ADDR_MCAUSE:   csr_cur = mcause;
            ADDR_MIP:      csr_cur[7] = timer_irq;
            ADDR_MCYCLE:   csr_cur = mcycle[DATA_LEN-1:0];
            ADDR_MINSTRET: csr_cur = minstret[DATA_LEN-1:0];
            ADDR_MCYCLEH: begin
                if (DATA_LEN == 32) csr_cur = DATA_LEN'(mcycle[63:32]);
                else                impl    = 1'b0;
            end
            ADDR_MINSTRETH: begin
                if (DATA_LEN == 32) csr_cur = DATA_LEN'(minstret[63:32]);
                else                impl    = 1'b0;
            end
            ADDR_MHARTID:  csr_cur = HART_ID;
            default:       impl = 1'b0;
        endcase
    end

    assign illegal = (ren | wen) & (~impl | (wen & (addr[11:10] == 2'b11)));
    assign rdata   = (ren & ~illegal) ? csr_cur : '0;

    always_comb begin
        case (op)
            2'b01:   csr_new = wdata;
            2'b10:   csr_new = csr_cur | wdata;
            2'b11:   csr_new = csr_cur & ~wdata;
            default: csr_new = csr_cur;
        endcase
    end

    // Trap and mret own the cycle; a coincident CSR write is dropped.
    assign csr_we  = wen & ~illegal & (op != 2'b00) & ~trap & ~mret;
    assign new_ext = 64'(csr_new);

    // A counter write replaces one half and cancels that cycle's increment.
    always_comb begin
        cycle_nxt   = mcycle + 64'd1;
        instret_nxt = minstret + 64'(instret_inc);
        if (csr_we) begin
            case (addr)
                ADDR_MCYCLE:
                    cycle_nxt = (DATA_LEN == 64) ? new_ext : {mcycle[63:32], new_ext[31:0]};
                ADDR_MCYCLEH:
                    cycle_nxt = {new_ext[31:0], mcycle[31:0]};
                ADDR_MINSTRET:
                    instret_nxt = (DATA_LEN == 64) ? new_ext : {minstret[63:32], new_ext[31:0]};
                ADDR_MINSTRETH:
                    instret_nxt = {new_ext[31:0], minstret[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_bit  <= 1'b0;
            mpie_bit <= 1'b0;
            mtie     <= 1'b0;
            mtvec    <= MTVEC_RST;
            mscratch <= '0;
            mepc_q   <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle   <= cycle_nxt;
            minstret <= instret_nxt;
            if (trap) begin
                mepc_q   <= pc & ALIGN_MASK;
                mcause   <= cause;
                mpie_bit <= mie_bit;
                mie_bit  <= 1'b0;
            end else if (mret) begin
                mie_bit  <= mpie_bit;
                mpie_bit <= 1'b1;
            end else if (csr_we) begin
                case (addr)
                    ADDR_MSTATUS: begin
                        mie_bit  <= csr_new[3];
                        mpie_bit <= csr_new[7];
                    end
                    ADDR_MIE:      mtie     <= csr_new[7];
                    ADDR_MTVEC:    mtvec    <= csr_new;
                    ADDR_MSCRATCH: mscratch <= csr_new;
                    ADDR_MEPC:     mepc_q   <= csr_new & ALIGN_MASK;
                    ADDR_MCAUSE:   mcause   <= csr_new;
                    default: ;
                endcase
            end
        end
    end

    // Vectored mode only applies to interrupts; exceptions always use the base.
    assign tvec_base   = mtvec & ALIGN_MASK;
    assign tvec_off    = {cause[DATA_LEN-3:0], 2'b00};
    assign trap_target = ((mtvec[1:0] == 2'b01) && cause[DATA_LEN-1]) ? tvec_base + tvec_off
                                                                       : tvec_base;

    assign irq_req = mie_bit & mtie & timer_irq;
    assign mepc    = mepc_q;

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit (DATA_LEN=32): reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_csr_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0105;
    localparam logic [31:0] HART_ID   = 32'h0000_0003;
    localparam logic [31:0] MISA_VAL  = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren, wen, trap, mret, instret_inc, timer_irq;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata, pc, cause;
    logic [31:0] rdata, trap_target, mepc;
    logic        illegal, irq_req;

    int checks = 0;
    int errors = 0;

    csr_unit #(
        .DATA_LEN (32),
        .MTVEC_RST(MTVEC_RST),
        .HART_ID  (HART_ID),
        .MISA_VAL (MISA_VAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ren        (ren),
        .wen        (wen),
        .op         (op),
        .addr       (addr),
        .wdata      (wdata),
        .pc         (pc),
        .trap       (trap),
        .cause      (cause),
        .mret       (mret),
        .instret_inc(instret_inc),
        .timer_irq  (timer_irq),
        .rdata      (rdata),
        .illegal    (illegal),
        .irq_req    (irq_req),
        .trap_target(trap_target),
        .mepc       (mepc)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_nv;
    logic [63:0] m_mcycle, m_minstret;
    bit          m_cinc, m_iinc;
    bit          model_ok = 1'b0;
    logic [11:0] impl_list [0:12] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                      12'h342, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                      12'hF14};

    function automatic bit m_impl(input logic [11:0] a);
        foreach (impl_list[i]) if (impl_list[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_illegal();
        if (!(ren || wen)) return 1'b0;
        return !m_impl(addr) || (wen && addr >= 12'hC00);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h301: return MISA_VAL;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return timer_irq ? 32'h80 : 32'h0;
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
            12'hF14: return HART_ID;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_apply(input logic [1:0] o, input logic [31:0] old,
                                            input logic [31:0] v);
        case (o)
            2'b01:   return v;
            2'b10:   return old | v;
            2'b11:   return old & ~v;
            default: return old;
        endcase
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] base;
        base = m_mtvec & ~32'd3;
        if (m_mtvec[1:0] == 2'b01 && cause[31]) return base + 4 * {1'b0, cause[30:0]};
        return base;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mstatus  = 32'h1800;
            m_mie      = 0;
            m_mtvec    = MTVEC_RST;
            m_mscratch = 0;
            m_mepc     = 0;
            m_mcause   = 0;
            m_mcycle   = 0;
            m_minstret = 0;
            model_ok   = 1'b1;
        end else if (model_ok) begin
            m_cinc = 1'b1;
            m_iinc = instret_inc;
            if (trap) begin
                m_mepc    = pc & ~32'd3;
                m_mcause  = cause;
                m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            end else if (mret) begin
                m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
            end else if (wen && !m_illegal() && op != 2'b00) begin
                m_nv = m_apply(op, m_read(addr), wdata);
                case (addr)
                    12'h300: m_mstatus  = 32'h1800 | (m_nv & 32'h88);
                    12'h304: m_mie      = m_nv & 32'h80;
                    12'h305: m_mtvec    = m_nv;
                    12'h340: m_mscratch = m_nv;
                    12'h341: m_mepc     = m_nv & ~32'd3;
                    12'h342: m_mcause   = m_nv;
                    12'hB00: begin m_mcycle[31:0]    = m_nv; m_cinc = 1'b0; end
                    12'hB80: begin m_mcycle[63:32]   = m_nv; m_cinc = 1'b0; end
                    12'hB02: begin m_minstret[31:0]  = m_nv; m_iinc = 1'b0; end
                    12'hB82: begin m_minstret[63:32] = m_nv; m_iinc = 1'b0; end
                    default: ;
                endcase
            end
            m_mcycle   = m_mcycle + 64'(m_cinc);
            m_minstret = m_minstret + 64'(m_iinc);
        end
    end

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("model_illegal", illegal, m_illegal());
            check("model_rdata", rdata, (ren && !m_illegal()) ? m_read(addr) : 32'h0);
            check("model_irq_req", irq_req, m_mstatus[3] & m_mie[7] & timer_irq);
            check("model_trap_target", trap_target, m_target());
            check("model_mepc", mepc, m_mepc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clr();
        ren = 0; wen = 0; op = 2'b00; addr = 12'h0; wdata = 0;
        pc = 0; cause = 0; trap = 0; mret = 0; instret_inc = 0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic csr(input logic r, input logic w, input logic [1:0] o,
                       input logic [11:0] a, input logic [31:0] d);
        ren = r; wen = w; op = o; addr = a; wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        timer_irq = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #3;
        check("rst_rdata", rdata, 0);
        check("rst_illegal", illegal, 0);
        check("rst_irq_req", irq_req, 0);
        check("rst_mepc", mepc, 0);
        check("rst_trap_target", trap_target, 32'h104);
        rst = 1'b0;
        csr(1, 0, 2'b00, 12'hB00, 0); #1;
        check("first_mcycle", rdata, 0);
        nxt(); csr(1, 0, 2'b00, 12'h300, 0); #2;
        check("rst_mstatus", rdata, 32'h1800);
        check("rd_illegal", illegal, 0);
        nxt(); csr(1, 0, 2'b00, 12'h305, 0); #2;
        check("rst_mtvec", rdata, 32'h105);
        nxt(); csr(1, 0, 2'b00, 12'hF14, 0); #2;
        check("mhartid", rdata, 32'h3);

        nxt(); csr(1, 1, 2'b01, 12'h340, 32'h0000FF0F); #2;
        check("scratch_w_pre", rdata, 0);
        nxt(); csr(1, 1, 2'b10, 12'h340, 32'h000000F0); #2;
        check("scratch_s_pre", rdata, 32'hFF0F);
        nxt(); csr(1, 1, 2'b11, 12'h340, 32'h0000000F); #2;
        check("scratch_c_pre", rdata, 32'hFFFF);
        nxt(); csr(1, 0, 2'b00, 12'h340, 0); #2;
        check("scratch_final", rdata, 32'hFFF0);
        nxt(); csr(0, 1, 2'b01, 12'h340, 32'hABCD); #2;
        check("wr_no_ren_rdata", rdata, 0);

        nxt(); csr(0, 1, 2'b01, 12'h300, 32'hFFFFFFFF);
        nxt(); csr(1, 0, 2'b00, 12'h300, 0); #2;
        check("mstatus_mask", rdata, 32'h1888);
        nxt(); csr(0, 1, 2'b01, 12'h300, 0);
        nxt(); csr(0, 1, 2'b10, 12'h300, 32'h8);
        nxt(); timer_irq = 1; csr(0, 1, 2'b10, 12'h304, 32'h80); #2;
        check("irq_before_mtie", irq_req, 0);
        nxt(); csr(0, 1, 2'b01, 12'h305, 32'h80001001); #2;
        check("irq_set", irq_req, 1);
        nxt(); trap = 1; cause = 32'h80000007; pc = 32'h80000102; #2;
        check("vec_target", trap_target, 32'h8000101C);
        nxt(); csr(1, 0, 2'b00, 12'h341, 0); #2;
        check("mepc_rd", rdata, 32'h80000100);
        check("mepc_out", mepc, 32'h80000100);
        check("irq_after_trap", irq_req, 0);
        nxt(); csr(1, 0, 2'b00, 12'h300, 0); #2;
        check("mstatus_trap", rdata, 32'h1880);
        nxt(); csr(1, 0, 2'b00, 12'h342, 0); #2;
        check("mcause", rdata, 32'h80000007);
        nxt(); mret = 1;
        nxt(); csr(1, 0, 2'b00, 12'h300, 0); #2;
        check("mstatus_mret", rdata, 32'h1888);
        check("irq_after_mret", irq_req, 1);
        nxt(); timer_irq = 0; csr(1, 0, 2'b00, 12'h344, 0); #2;
        check("irq_timer_low", irq_req, 0);
        check("mip_low", rdata, 0);
        nxt(); timer_irq = 1; csr(1, 0, 2'b00, 12'h344, 0); #2;
        check("mip_high", rdata, 32'h80);

        nxt(); csr(0, 1, 2'b01, 12'hB00, 32'hFFFFFFFF);
        nxt(); csr(0, 1, 2'b01, 12'hB80, 0);
        nxt(); csr(1, 0, 2'b00, 12'hB00, 0); #2;
        check("mcycle_held", rdata, 32'hFFFFFFFF);
        nxt(); csr(1, 0, 2'b00, 12'hB00, 0); #2;
        check("mcycle_wrap", rdata, 0);
        nxt(); csr(1, 0, 2'b00, 12'hB80, 0); #2;
        check("mcycleh_carry", rdata, 1);
        nxt(); csr(0, 1, 2'b01, 12'hB02, 32'h10); instret_inc = 1;
        nxt(); csr(1, 0, 2'b00, 12'hB02, 0); instret_inc = 1; #2;
        check("minstret_wr", rdata, 32'h10);
        nxt(); csr(1, 0, 2'b00, 12'hB02, 0); #2;
        check("minstret_inc", rdata, 32'h11);
        nxt(); csr(1, 0, 2'b00, 12'hB82, 0); #2;
        check("minstreth", rdata, 0);

        nxt(); csr(1, 1, 2'b01, 12'hF14, 32'hFF); #2;
        check("ill_ro_write", illegal, 1);
        check("ill_ro_rdata", rdata, 0);
        nxt(); csr(1, 0, 2'b00, 12'h7C0, 0); #2;
        check("ill_unimpl", illegal, 1);
        check("ill_unimpl_rdata", rdata, 0);
        nxt(); csr(1, 1, 2'b01, 12'hC00, 32'h1); #2;
        check("ill_c00", illegal, 1);
        nxt(); csr(1, 0, 2'b00, 12'hF14, 0); #2;
        check("hartid_kept", rdata, 32'h3);
        nxt(); csr(1, 1, 2'b01, 12'h301, 0); #2;
        check("misa_wr_legal", illegal, 0);
        check("misa_rd", rdata, 32'h40000100);

        nxt(); trap = 1; mret = 1; cause = 32'h5; pc = 32'h200;
        csr(0, 1, 2'b01, 12'h340, 32'h1234); #2;
        check("exc_target", trap_target, 32'h80001000);
        nxt(); csr(1, 0, 2'b00, 12'h340, 0); #2;
        check("scratch_dropped", rdata, 32'hABCD);
        check("mepc_exc", mepc, 32'h200);
        nxt(); csr(1, 0, 2'b00, 12'h300, 0); #2;
        check("trap_beats_mret", rdata, 32'h1880);

        nxt(); rst = 1; trap = 1; pc = 32'h400; csr(0, 1, 2'b01, 12'h340, 32'h77);
        nxt(); rst = 0; csr(1, 0, 2'b00, 12'h340, 0); #2;
        check("rst_scratch", rdata, 0);
        check("rst_mepc2", mepc, 0);
        check("rst_target2", trap_target, 32'h104);
        nxt(); csr(1, 0, 2'b00, 12'h300, 0); #2;
        check("rst_mstatus2", rdata, 32'h1800);
        nxt();
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
